data_sram_responder: RTL and testbench

Slave end of the CPU data-SRAM port: answers every data_sram_en access with fixed one-cycle read latency and byte-granular writes. Decodes two regions: local data RAM, and a small MMIO block (LED, switch, free-running timer with compare interrupt). Instantiated beside mycpu_top in the SoC top, wired directly to its data_sram_* outputs/inputs.

---
 rtl/data_sram_responder.sv | 173 +++++++++++++++++
 tb/tb_data_sram_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: slave side of the CPU data-SRAM port.
// Serves a local word-addressed data RAM and a small MMIO block
// (LED, switch, free-running timer with sticky compare interrupt).
// Every access responds with one cycle of read latency.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [15:0] MMIO_HI    = 16'hBFAF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned OFF_W    = 14;

  // MMIO word offsets (byte offset >> 2)
  localparam logic [OFF_W-1:0] OFF_LED     = 14'h0000;
  localparam logic [OFF_W-1:0] OFF_SWITCH  = 14'h0001;
  localparam logic [OFF_W-1:0] OFF_COUNT   = 14'h0002;
  localparam logic [OFF_W-1:0] OFF_COMPARE = 14'h0003;
  localparam logic [OFF_W-1:0] OFF_IRQ     = 14'h0004;

  // Byte-lane merge of new data into an existing word
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0]           mem [DEPTH];

  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  irq;
  logic [7:0]            switch_meta;
  logic [7:0]            switch_sync;

  logic                  is_mmio_c;
  logic [OFF_W-1:0]      word_off_c;
  logic [ADDR_WIDTH-1:0] ram_idx_c;
  logic                  wr_c;
  logic                  ram_wr_c;
  logic                  mmio_wr_c;
  logic                  led_wr_c;
  logic                  count_wr_c;
  logic                  compare_wr_c;
  logic                  irq_clr_c;
  logic [31:0]           led_word_c;
  logic [31:0]           count_word_c;
  logic [31:0]           compare_word_c;
  logic [31:0]           mmio_rdata_c;
  logic                  unused_c;

  // Address decode: MMIO window vs. RAM with upper bits aliased
  assign is_mmio_c  = (data_sram_addr[31:16] == MMIO_HI);
  assign word_off_c = data_sram_addr[15:2];
  assign ram_idx_c  = data_sram_addr[ADDR_WIDTH+1:2];

  assign wr_c      = data_sram_en && (data_sram_wen != 4'b0000);
  assign ram_wr_c  = wr_c && !is_mmio_c;
  assign mmio_wr_c = wr_c && is_mmio_c;

  assign led_wr_c     = mmio_wr_c && (word_off_c == OFF_LED);
  assign count_wr_c   = mmio_wr_c && (word_off_c == OFF_COUNT);
  assign compare_wr_c = mmio_wr_c && (word_off_c == OFF_COMPARE);
  assign irq_clr_c    = mmio_wr_c && (word_off_c == OFF_IRQ) &&
                        data_sram_wen[0] && data_sram_wdata[0];

  assign led_word_c     = byte_merge({16'h0000, led}, data_sram_wdata, data_sram_wen);
  assign count_word_c   = byte_merge(count, data_sram_wdata, data_sram_wen);
  assign compare_word_c = byte_merge(compare, data_sram_wdata, data_sram_wen);

  // Byte-address bits and LED upper half are intentionally dropped
  assign unused_c = ^{data_sram_addr[1:0], led_word_c[31:16]};

  // MMIO read mux, using register values before this cycle's update
  always_comb begin
    mmio_rdata_c = 32'h0000_0000;
    case (word_off_c)
      OFF_LED:     mmio_rdata_c = {16'h0000, led};
      OFF_SWITCH:  mmio_rdata_c = {24'h000000, switch_sync};
      OFF_COUNT:   mmio_rdata_c = count;
      OFF_COMPARE: mmio_rdata_c = compare;
      OFF_IRQ:     mmio_rdata_c = {31'h0000_0000, irq};
      default:     mmio_rdata_c = 32'h0000_0000;
    endcase
  end

  // Data RAM byte writes; contents are not reset
  always_ff @(posedge clk) begin
    if (ram_wr_c) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[ram_idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read response register: old contents (read-before-write), holds when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sram_rdata <= 32'h0000_0000;
    end else if (data_sram_en) begin
      data_sram_rdata <= is_mmio_c ? mmio_rdata_c : mem[ram_idx_c];
    end
  end

  // LED register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= 16'h0000;
    end else if (led_wr_c) begin
      led <= led_word_c[15:0];
    end
  end

  // Free-running counter; a CPU write replaces the increment for that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 32'h0000_0000;
    end else if (count_wr_c) begin
      count <= count_word_c;
    end else begin
      count <= count + 32'd1;
    end
  end

  // Compare register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare <= 32'hFFFF_FFFF;
    end else if (compare_wr_c) begin
      compare <= compare_word_c;
    end
  end

  // Sticky compare interrupt; a match outranks a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (count == compare) begin
      irq <= 1'b1;
    end else if (irq_clr_c) begin
      irq <= 1'b0;
    end
  end

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      switch_meta <= 8'h00;
      switch_sync <= 8'h00;
    end else begin
      switch_meta <= switch;
      switch_sync <= switch_meta;
    end
  end

  assign timer_irq = irq;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        irq;

  int total;
  int bad;

  localparam logic [31:0] A_LED   = 32'hBFAF_0000;
  localparam logic [31:0] A_SW    = 32'hBFAF_0004;
  localparam logic [31:0] A_COUNT = 32'hBFAF_0008;
  localparam logic [31:0] A_CMP   = 32'hBFAF_000C;
  localparam logic [31:0] A_IRQ   = 32'hBFAF_0010;
  localparam logic [31:0] A_UNMAP = 32'hBFAF_0040;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .timer_irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: inputs held across one rising edge, returns 1 time unit after it
  task automatic acc(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en    = 1'b1;
    wen   = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    en    = 1'b0;
    wen   = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    en    = 1'b0;
    wen   = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;
    sw    = 8'h00;
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    idle(2);
    reset = 1'b0;
    idle(1);

    // RAM byte writes
    acc(4'hF, 32'h0000_0100, 32'h1122_3344);
    acc(4'b0010, 32'h0000_0100, 32'h0000_AA00);
    check("ram_rbw_partial", rdata, 32'h1122_3344);
    acc(4'h0, 32'h0000_0100, 32'h0);
    check("ram_byte_write", rdata, 32'h1122_AA44);

    // Read-before-write
    acc(4'hF, 32'h0000_0200, 32'hDEAD_BEEF);
    acc(4'hF, 32'h0000_0200, 32'h0000_0000);
    check("ram_rbw_full", rdata, 32'hDEAD_BEEF);
    acc(4'h0, 32'h0000_0200, 32'h0);
    check("ram_after_write", rdata, 32'h0);

    // Upper address bits alias onto the same RAM word
    acc(4'hF, 32'h4000_0300, 32'hCAFE_F00D);
    acc(4'h0, 32'h0000_0300, 32'h0);
    check("ram_alias", rdata, 32'hCAFE_F00D);

    // LED and unmapped MMIO
    acc(4'hF, A_LED, 32'hFFFF_1234);
    check("led_rbw", rdata, 32'h0);
    check("led_out", {16'h0, led}, 32'h0000_1234);
    acc(4'h0, A_LED, 32'h0);
    check("led_read", rdata, 32'h0000_1234);
    acc(4'b0010, A_LED, 32'h0000_AB00);
    check("led_byte", {16'h0, led}, 32'h0000_AB34);
    acc(4'hF, A_UNMAP, 32'hFFFF_FFFF);
    acc(4'h0, A_UNMAP, 32'h0);
    check("unmapped_read", rdata, 32'h0);

    // Switch synchronizer
    sw = 8'hA5;
    acc(4'h0, A_SW, 32'h0);
    check("switch_early", rdata, 32'h0);
    idle(1);
    acc(4'h0, A_SW, 32'h0);
    check("switch_synced", rdata, 32'h0000_00A5);
    acc(4'hF, A_SW, 32'h0000_0000);
    acc(4'h0, A_SW, 32'h0);
    check("switch_ro", rdata, 32'h0000_00A5);

    // Timer wrap and compare interrupt
    acc(4'hF, A_COUNT, 32'hFFFF_FFFE);
    acc(4'hF, A_CMP, 32'h0000_0001);
    check("cmp_rbw", rdata, 32'hFFFF_FFFF);
    acc(4'h0, A_COUNT, 32'h0);
    check("count_ffff", rdata, 32'hFFFF_FFFF);
    acc(4'h0, A_COUNT, 32'h0);
    check("count_wrap0", rdata, 32'h0);
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq_rise", {31'h0, irq}, 32'h1);
    idle(3);
    check("irq_sticky", {31'h0, irq}, 32'h1);
    acc(4'h0, A_IRQ, 32'h0);
    check("irq_read", rdata, 32'h1);
    acc(4'h1, A_IRQ, 32'h0000_0001);
    check("irq_clear", {31'h0, irq}, 32'h0);

    // Set/clear collision: count reaches compare in the clear cycle
    acc(4'hF, A_COUNT, 32'h0000_0100);
    acc(4'hF, A_CMP, 32'h0000_0103);
    idle(2);
    check("irq_pre_collide", {31'h0, irq}, 32'h0);
    acc(4'h1, A_IRQ, 32'h0000_0001);
    check("irq_collide", {31'h0, irq}, 32'h1);

    // Asynchronous reset mid-access
    acc(4'hF, A_LED, 32'h0000_00FF);
    acc(4'h0, A_LED, 32'h0);
    check("led_ff_read", rdata, 32'h0000_00FF);
    en   = 1'b1;
    wen  = 4'h0;
    addr = A_LED;
    #2;
    reset = 1'b1;
    #1;
    check("async_rdata", rdata, 32'h0);
    check("async_led", {16'h0, led}, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc(4'h0, 32'h0000_0100, 32'h0);
    check("ram_after_reset", rdata, 32'h1122_AA44);
    acc(4'h0, A_CMP, 32'h0);
    check("cmp_after_reset", rdata, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
